right_shift_rot_32: RTL and testbench

RIGHT_SHIFT_ROT_32 -- requirements
Module: right_shift_rot_32

---
 rtl/right_shift_rot_32_pkg.sv | 12 +
 rtl/right_shift_rot_32_barrel_stage.sv | 27 ++
 rtl/right_shift_rot_32.sv | 49 ++++
 tb/tb_right_shift_rot_32.sv | 126 ++++++++++++
 4 files changed

// File: rtl/right_shift_rot_32_pkg.sv
// Shared widths and operation encoding for the 32-bit right shifter/rotator.
package right_shift_rot_32_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;

    typedef enum logic {
        OP_SHR = 1'b0,
        OP_ROR = 1'b1
    } op_e;

endpackage

// File: rtl/right_shift_rot_32_barrel_stage.sv
// One log-shifter stage: shifts or rotates right by a fixed AMT when enabled.
module barrel_stage
    import right_shift_rot_32_pkg::*;
#(
    parameter int unsigned WIDTH = right_shift_rot_32_pkg::WIDTH,
    parameter int unsigned AMT   = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic             rotate_i,
    output logic [WIDTH-1:0] data_c
);

    logic [WIDTH-1:0] shr_c;
    logic [WIDTH-1:0] ror_c;

    always_comb begin
        shr_c  = data_i >> AMT;
        // Low AMT bits wrap around to the top for rotate.
        ror_c  = shr_c | (data_i << (WIDTH - AMT));
        data_c = data_i;
        if (en_i) begin
            data_c = (op_e'(rotate_i) == OP_ROR) ? ror_c : shr_c;
        end
    end

endmodule

// File: rtl/right_shift_rot_32.sv
// Registered 32-bit logical shift-right / rotate-right built from a five-stage log shifter.
module right_shift_rot_32
    import right_shift_rot_32_pkg::*;
#(
    parameter int unsigned WIDTH = right_shift_rot_32_pkg::WIDTH,
    parameter int unsigned SHW   = right_shift_rot_32_pkg::SHW
) (
    input  logic [WIDTH-1:0] in,
    input  logic             rotate,
    input  logic [SHW-1:0]   select,
    output logic [WIDTH-1:0] out,
    input  logic             clk,
    input  logic             rst_n
);

    logic [WIDTH-1:0] stage_c [SHW+1];
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    assign stage_c[0] = in;

    // Stage k moves data by 2^k when select[k] is set.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_stage #(
            .WIDTH (WIDTH),
            .AMT   (1 << k)
        ) u_stage (
            .data_i   (stage_c[k]),
            .en_i     (select[k]),
            .rotate_i (rotate),
            .data_c   (stage_c[k+1])
        );
    end

    always_comb begin
        out_d = stage_c[SHW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_right_shift_rot_32.sv
// Scoreboard bench for right_shift_rot_32: directed corner vectors, async reset, random sweep.
module tb_right_shift_rot_32;

    logic [31:0] in;
    logic        rotate;
    logic [4:0]  select;
    logic [31:0] out;
    logic        clk;
    logic        rst_n;

    int unsigned n_vec;
    int unsigned n_err;
    logic [31:0] sb[$];

    right_shift_rot_32 dut (
        .in     (in),
        .rotate (rotate),
        .select (select),
        .out    (out),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [31:0] d, input logic rot, input logic [4:0] sel);
        logic [31:0] r;
        int s;
        s = int'(sel);
        for (int i = 0; i < 32; i++) begin
            if (rot)             r[i] = d[(i + s) % 32];
            else if (i + s < 32) r[i] = d[i + s];
            else                 r[i] = 1'b0;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive at negedge, push the model result, compare after the next rising edge.
    task automatic run_vec(input string tag, input logic [31:0] d, input logic rot, input logic [4:0] sel);
        @(negedge clk);
        in     = d;
        rotate = rot;
        select = sel;
        sb.push_back(ref_model(d, rot, sel));
        @(posedge clk);
        #1;
        if (sb.size() == 0) check({tag, "_sb_empty"}, out, 32'hxxxx_xxxx);
        else                check(tag, out, sb.pop_front());
    endtask

    initial begin
        logic [31:0] held;
        n_vec  = 0;
        n_err  = 0;
        in     = '0;
        rotate = 1'b0;
        select = '0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_async", out, 32'h0);
        @(posedge clk);
        #1 check("reset_hold", out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("shr_25", 32'hF000_0001, 1'b0, 5'd25);
        check("shr_25_const", out, 32'h0000_0078);
        run_vec("ror_25", 32'hF000_0001, 1'b1, 5'd25);
        check("ror_25_const", out, 32'h0000_00F8);

        // Async reset mid-cycle discards the in-flight result.
        #2 rst_n = 1'b0;
        in = 32'hDEAD_BEEF; select = 5'd3; rotate = 1'b0;
        #1 check("rst_mid_cycle", out, 32'h0);
        @(posedge clk);
        #1 check("rst_held_edge", out, 32'h0);
        @(negedge clk);
        in = 32'hF000_0001; rotate = 1'b1; select = 5'd25;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst_release", out, 32'h0000_00F8);

        run_vec("shr_sel0", 32'hA5A5_5A5A, 1'b0, 5'd0);
        check("shr_sel0_const", out, 32'hA5A5_5A5A);
        run_vec("ror_sel0", 32'hA5A5_5A5A, 1'b1, 5'd0);
        check("ror_sel0_const", out, 32'hA5A5_5A5A);
        run_vec("shr_sel31", 32'h8000_0000, 1'b0, 5'd31);
        check("shr_sel31_const", out, 32'h0000_0001);
        run_vec("ror_sel31", 32'h0000_0001, 1'b1, 5'd31);
        check("ror_sel31_const", out, 32'h0000_0002);
        run_vec("shr_nosign", 32'hFFFF_FFFF, 1'b0, 5'd4);
        check("shr_nosign_const", out, 32'h0FFF_FFFF);

        for (int i = 0; i < 1000; i++) begin
            run_vec("rand", $urandom, 1'($urandom_range(1)), 5'($urandom_range(31)));
            // Inputs wiggling between edges must not disturb the registered output.
            held   = out;
            in     = $urandom;
            rotate = ~rotate;
            select = select + 5'd7;
            #2 check("hold_between_edges", out, held);
        end

        if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
